updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 104 ++++++++++
 tb/tb_updown_mod_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap or saturate at the limits,
// registered status outputs and sticky overflow/underflow/load-error flags.
module updown_mod_counter #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned MAX_COUNT = 2**WIDTH-1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_flags,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             ovf,
    output logic             unf,
    output logic             ld_err
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_V};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             at_max_q, at_zero_q, wrap_q;
    logic             ovf_q, unf_q, ld_err_q;
    logic             wrap_d, ovf_set, unf_set, ld_err_set;
    logic [WIDTH:0]   cnt_x, up_x, dn_x;

    assign cnt_x = {1'b0, cnt_q};
    assign up_x  = cnt_x + {{WIDTH{1'b0}}, 1'b1};
    assign dn_x  = cnt_x - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        ld_err_set = 1'b0;
        if (ld) begin
            if ({1'b0, data_in} > MAX_X) begin
                cnt_d      = MAX_V;
                ld_err_set = 1'b1;
            end else begin
                cnt_d = data_in;
            end
        end else if (inc && dec) begin
            cnt_d = cnt_q;
        end else if (inc) begin
            if (cnt_x == MAX_X) begin
                ovf_set = 1'b1;
                if (!SATURATE) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                cnt_d = up_x[WIDTH-1:0];
            end
        end else if (dec) begin
            if (cnt_q == '0) begin
                unf_set = 1'b1;
                if (!SATURATE) begin
                    cnt_d  = MAX_V;
                    wrap_d = 1'b1;
                end
            end else begin
                cnt_d = dn_x[WIDTH-1:0];
            end
        end
    end

    // Status bits derive from cnt_d so they line up with the new data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            at_max_q  <= 1'b0;
            at_zero_q <= 1'b1;
            wrap_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            at_max_q  <= (cnt_d == MAX_V);
            at_zero_q <= (cnt_d == '0);
            wrap_q    <= wrap_d;
            ovf_q     <= ovf_set    | (ovf_q    & ~clr_flags);
            unf_q     <= unf_set    | (unf_q    & ~clr_flags);
            ld_err_q  <= ld_err_set | (ld_err_q & ~clr_flags);
        end
    end

    assign data_out = cnt_q;
    assign at_max   = at_max_q;
    assign at_zero  = at_zero_q;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: three counter configurations driven by shared stimulus,
// each task checks the instance that exercises its scenario.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst, ld, inc, dec, clr_flags;
    logic [2:0] data_in;

    logic [2:0] a_do, b_do, c_do;
    logic       a_mx, a_z, a_w, a_o, a_u, a_l;
    logic       b_mx, b_z, b_w, b_o, b_u, b_l;
    logic       c_mx, c_z, c_w, c_o, c_u, c_l;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // a: wrap, max 5   b: saturate, max 5   c: wrap, max 7
    updown_mod_counter #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec),
        .clr_flags(clr_flags), .data_in(data_in), .data_out(a_do),
        .at_max(a_mx), .at_zero(a_z), .wrap(a_w),
        .ovf(a_o), .unf(a_u), .ld_err(a_l));

    updown_mod_counter #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec),
        .clr_flags(clr_flags), .data_in(data_in), .data_out(b_do),
        .at_max(b_mx), .at_zero(b_z), .wrap(b_w),
        .ovf(b_o), .unf(b_u), .ld_err(b_l));

    updown_mod_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b0)) u_c (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec),
        .clr_flags(clr_flags), .data_in(data_in), .data_out(c_do),
        .at_max(c_mx), .at_zero(c_z), .wrap(c_w),
        .ovf(c_o), .unf(c_u), .ld_err(c_l));

    task automatic idle();
        rst = 0; ld = 0; inc = 0; dec = 0; clr_flags = 0; data_in = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        idle(); ld = 1; inc = 1; data_in = 3'd3; rst = 1;
        step(); idle();
        tests++; if (a_do !== 3'd0) begin failed++; $display("FAIL reset_a_do got %0d exp 0", a_do); end
        tests++; if (a_z !== 1'b1) begin failed++; $display("FAIL reset_a_zero got %b exp 1", a_z); end
        tests++; if ({a_mx, a_w, a_o, a_u, a_l} !== 5'b0) begin failed++; $display("FAIL reset_a_flags got %b exp 00000", {a_mx, a_w, a_o, a_u, a_l}); end
        tests++; if ({b_do, b_z} !== 4'b0001) begin failed++; $display("FAIL reset_b got %b exp 0001", {b_do, b_z}); end
        tests++; if ({c_do, c_z, c_mx} !== 5'b00010) begin failed++; $display("FAIL reset_c got %b exp 00010", {c_do, c_z, c_mx}); end
    endtask

    task automatic test_wrap_up();
        do_reset();
        ld = 1; data_in = 3'd4; step(); ld = 0;
        tests++; if (a_do !== 3'd4) begin failed++; $display("FAIL wrapup_load got %0d exp 4", a_do); end
        inc = 1; step();
        tests++; if ({a_do, a_mx, a_w, a_o} !== {3'd5, 3'b100}) begin failed++; $display("FAIL wrapup_at5 got %b exp 101100", {a_do, a_mx, a_w, a_o}); end
        step(); inc = 0;
        tests++; if ({a_do, a_z, a_w, a_o, a_mx} !== {3'd0, 4'b1110}) begin failed++; $display("FAIL wrapup_at0 got %b exp 0001110", {a_do, a_z, a_w, a_o, a_mx}); end
        step();
        tests++; if ({a_do, a_w, a_o} !== {3'd0, 2'b01}) begin failed++; $display("FAIL wrapup_pulse_end got %b exp 00001", {a_do, a_w, a_o}); end
    endtask

    task automatic test_sat_down();
        do_reset();
        dec = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if ({b_do, b_z, b_w} !== {3'd0, 2'b10}) begin failed++; $display("FAIL satdown_%0d got %b exp 00010", i, {b_do, b_z, b_w}); end
        end
        dec = 0;
        tests++; if (b_u !== 1'b1) begin failed++; $display("FAIL satdown_unf got %b exp 1", b_u); end
        ld = 1; data_in = 3'd5; step(); ld = 0; inc = 1; step(); inc = 0;
        tests++; if ({b_do, b_mx, b_w, b_o} !== {3'd5, 3'b101}) begin failed++; $display("FAIL satup_hold got %b exp 101101", {b_do, b_mx, b_w, b_o}); end
        clr_flags = 1; step(); clr_flags = 0;
        tests++; if ({b_o, b_u, b_do} !== {2'b00, 3'd5}) begin failed++; $display("FAIL sat_clr got %b exp 00101", {b_o, b_u, b_do}); end
    endtask

    task automatic test_load_clamp();
        do_reset();
        ld = 1; data_in = 3'd7; step(); ld = 0;
        tests++; if ({a_do, a_mx, a_l} !== {3'd5, 2'b11}) begin failed++; $display("FAIL clamp_a got %b exp 10111", {a_do, a_mx, a_l}); end
        tests++; if ({c_do, c_mx, c_l} !== {3'd7, 2'b10}) begin failed++; $display("FAIL clamp_c_legal got %b exp 11110", {c_do, c_mx, c_l}); end
        clr_flags = 1; step(); clr_flags = 0;
        tests++; if ({a_l, a_do} !== {1'b0, 3'd5}) begin failed++; $display("FAIL clamp_clr got %b exp 0101", {a_l, a_do}); end
        ld = 1; data_in = 3'd6; clr_flags = 1; step(); idle();
        tests++; if ({a_l, a_do} !== {1'b1, 3'd5}) begin failed++; $display("FAIL clamp_set_wins got %b exp 1101", {a_l, a_do}); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ld = 1; data_in = 3'd2; step(); ld = 0;
        inc = 1; dec = 1; step();
        tests++; if ({a_do, a_w, a_o, a_u} !== {3'd2, 3'b000}) begin failed++; $display("FAIL sim_incdec got %b exp 010000", {a_do, a_w, a_o, a_u}); end
        dec = 0; ld = 1; data_in = 3'd3; step(); idle();
        tests++; if (a_do !== 3'd3) begin failed++; $display("FAIL sim_ld_inc got %0d exp 3", a_do); end
    endtask

    task automatic test_set_vs_clear();
        do_reset();
        ld = 1; data_in = 3'd5; step(); ld = 0;
        inc = 1; clr_flags = 1; step(); clr_flags = 0;
        tests++; if ({a_do, a_o, a_w} !== {3'd0, 2'b11}) begin failed++; $display("FAIL setclr got %b exp 00011", {a_do, a_o, a_w}); end
        step();
        tests++; if (a_do !== 3'd1) begin failed++; $display("FAIL setclr_next got %0d exp 1", a_do); end
        rst = 1; step(); idle();
        tests++; if ({a_do, a_z, a_o, a_u, a_l, a_w} !== {3'd0, 5'b10000}) begin failed++; $display("FAIL rst_midcount got %b exp 00010000", {a_do, a_z, a_o, a_u, a_l, a_w}); end
    endtask

    task automatic test_wrap_down_full();
        do_reset();
        dec = 1; step(); dec = 0;
        tests++; if ({c_do, c_w, c_u, c_mx, c_z} !== {3'd7, 4'b1110}) begin failed++; $display("FAIL wrapdown_c got %b exp 1111110", {c_do, c_w, c_u, c_mx, c_z}); end
        tests++; if ({a_do, a_w, a_u, a_mx} !== {3'd5, 3'b111}) begin failed++; $display("FAIL wrapdown_a got %b exp 101111", {a_do, a_w, a_u, a_mx}); end
    endtask

    task automatic test_back_to_back();
        int exp_a, exp_c;
        do_reset();
        exp_a = 0; exp_c = 0;
        inc = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            exp_a = (exp_a + 1) % 6;
            exp_c = (exp_c + 1) % 8;
            tests++; if (a_do !== exp_a[2:0] || c_do !== exp_c[2:0]) begin failed++; $display("FAIL b2b_up_%0d got a=%0d c=%0d exp a=%0d c=%0d", i, a_do, c_do, exp_a, exp_c); end
        end
        inc = 0; dec = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_a = (exp_a + 5) % 6;
            exp_c = (exp_c + 7) % 8;
            tests++; if (a_do !== exp_a[2:0] || c_do !== exp_c[2:0]) begin failed++; $display("FAIL b2b_dn_%0d got a=%0d c=%0d exp a=%0d c=%0d", i, a_do, c_do, exp_a, exp_c); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_simultaneous();
        test_set_vs_clear();
        test_wrap_down_full();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
